// File: rtl/frame_wr_addr_gen_if.sv
// AXI write-address channel plus write-response completion pulse, as seen by
// the frame write address generator.
interface frame_wr_addr_gen_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0]            awlen;
  logic                  awvalid;
  logic                  awready;
  logic                  burst_done;

  modport master (
    output awaddr,
    output awlen,
    output awvalid,
    input  awready,
    input  burst_done
  );

  modport slave (
    input  awaddr,
    input  awlen,
    input  awvalid,
    output awready,
    output burst_done
  );
endinterface

// File: rtl/frame_wr_addr_gen.sv
// Frame write address generator: requests a bank switch per frame, then walks
// the bank with one outstanding AXI write burst at a time.
module frame_wr_addr_gen #(
  parameter int unsigned BURST_LEN      = 16,
  parameter int unsigned AXI_DATA_WIDTH = 256,
  parameter int unsigned ADDR_WIDTH     = 32
) (
  input  logic                  ddr_clk,
  input  logic                  rst,
  input  logic                  frame_start,
  input  logic [23:0]           frame_words,
  input  logic [11:0]           fifo_rd_count,
  output logic                  wr_sw,
  input  logic                  wr_sw_ack,
  input  logic [ADDR_WIDTH-1:0] wr_start_addr,
  frame_wr_addr_gen_if.master   aw,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  overrun
);

  localparam int unsigned BYTES_PER_BEAT = AXI_DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE,
    SWITCH,
    LOAD,
    WAIT_DATA,
    ADDR,
    RESP,
    DONE
  } state_t;

  state_t                r_state;
  logic [23:0]           r_remaining;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [8:0]            r_beats;
  logic                  r_wr_sw;
  logic                  r_awvalid;
  logic [ADDR_WIDTH-1:0] r_awaddr;
  logic [7:0]            r_awlen;
  logic                  r_frame_done;
  logic                  r_overrun;

  logic [8:0]            w_beats;
  logic                  w_fifo_ok;
  logic [ADDR_WIDTH-1:0] w_incr;
  logic [23:0]           w_rem_next;

  // Remaining is below BURST_LEN (<= 256) in the short case, so 9 bits suffice.
  always_comb begin
    w_beats = 9'(BURST_LEN);
    if (r_remaining < 24'(BURST_LEN)) begin
      w_beats = r_remaining[8:0];
    end
  end

  assign w_fifo_ok  = ({1'b0, fifo_rd_count} >= {4'b0000, w_beats});
  assign w_incr     = ADDR_WIDTH'(r_beats) * ADDR_WIDTH'(BYTES_PER_BEAT);
  assign w_rem_next = r_remaining - {15'b0, r_beats};

  always_ff @(posedge ddr_clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_remaining  <= '0;
      r_addr       <= '0;
      r_beats      <= '0;
      r_wr_sw      <= 1'b0;
      r_awvalid    <= 1'b0;
      r_awaddr     <= '0;
      r_awlen      <= '0;
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (frame_start && (r_state != IDLE)) begin
        r_overrun <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (frame_start) begin
            r_remaining <= frame_words;
            r_wr_sw     <= 1'b1;
            r_state     <= SWITCH;
          end
        end
        // Bank base is only guaranteed valid alongside the ack, so it is
        // captured here rather than one cycle later in LOAD.
        SWITCH: begin
          if (wr_sw_ack) begin
            r_wr_sw <= 1'b0;
            r_addr  <= wr_start_addr;
            r_state <= LOAD;
          end
        end
        LOAD: begin
          if (r_remaining == '0) begin
            r_frame_done <= 1'b1;
            r_state      <= DONE;
          end else begin
            r_state <= WAIT_DATA;
          end
        end
        WAIT_DATA: begin
          if (w_fifo_ok) begin
            r_beats   <= w_beats;
            r_awaddr  <= r_addr;
            r_awlen   <= 8'(w_beats - 9'd1);
            r_awvalid <= 1'b1;
            r_state   <= ADDR;
          end
        end
        ADDR: begin
          if (aw.awready) begin
            r_awvalid <= 1'b0;
            r_state   <= RESP;
          end
        end
        RESP: begin
          if (aw.burst_done) begin
            r_addr      <= r_addr + w_incr;
            r_remaining <= w_rem_next;
            if (w_rem_next == '0) begin
              r_frame_done <= 1'b1;
              r_state      <= DONE;
            end else begin
              r_state <= WAIT_DATA;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign wr_sw      = r_wr_sw;
  assign aw.awvalid = r_awvalid;
  assign aw.awaddr  = r_awaddr;
  assign aw.awlen   = r_awlen;
  assign busy       = (r_state != IDLE);
  assign frame_done = r_frame_done;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_frame_wr_addr_gen.sv
// Directed bench for frame_wr_addr_gen with a burst scoreboard filled from a
// reference address walk at each frame start.
module tb_frame_wr_addr_gen;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
  } burst_t;

  logic        ddr_clk;
  logic        rst;
  logic        frame_start;
  logic [23:0] frame_words;
  logic [11:0] fifo_rd_count;
  logic        wr_sw;
  logic        wr_sw_ack;
  logic [31:0] wr_start_addr;
  logic        busy;
  logic        frame_done;
  logic        overrun;

  int unsigned n_vec;
  int unsigned n_err;
  burst_t      sb[$];

  frame_wr_addr_gen_if #(.ADDR_WIDTH(32)) aw_if ();

  frame_wr_addr_gen #(
    .BURST_LEN(16),
    .AXI_DATA_WIDTH(256),
    .ADDR_WIDTH(32)
  ) dut (
    .ddr_clk(ddr_clk),
    .rst(rst),
    .frame_start(frame_start),
    .frame_words(frame_words),
    .fifo_rd_count(fifo_rd_count),
    .wr_sw(wr_sw),
    .wr_sw_ack(wr_sw_ack),
    .wr_start_addr(wr_start_addr),
    .aw(aw_if),
    .busy(busy),
    .frame_done(frame_done),
    .overrun(overrun)
  );

  initial ddr_clk = 1'b0;
  always #5 ddr_clk = ~ddr_clk;

  task automatic step();
    @(posedge ddr_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_wr_sw"},      64'(wr_sw),         64'(0));
    chk({tag, "_awvalid"},    64'(aw_if.awvalid), 64'(0));
    chk({tag, "_awaddr"},     64'(aw_if.awaddr),  64'(0));
    chk({tag, "_awlen"},      64'(aw_if.awlen),   64'(0));
    chk({tag, "_busy"},       64'(busy),          64'(0));
    chk({tag, "_frame_done"}, 64'(frame_done),    64'(0));
    chk({tag, "_overrun"},    64'(overrun),       64'(0));
  endtask

  // Reference walk: 16-beat bursts of 32 bytes each, short final burst.
  task automatic push_frame(input logic [23:0] words, input logic [31:0] base);
    logic [31:0] a;
    int unsigned rem;
    int unsigned b;
    burst_t      e;
    a   = base;
    rem = int'(words);
    while (rem > 0) begin
      b      = (rem > 16) ? 16 : rem;
      e.addr = a;
      e.len  = 8'(b - 1);
      sb.push_back(e);
      a   = a + 32'(b * 32);
      rem = rem - b;
    end
  endtask

  task automatic start_frame(input logic [23:0] words, input logic [31:0] base,
                             input int unsigned ack_delay);
    push_frame(words, base);
    frame_start = 1'b1;
    frame_words = words;
    step();
    frame_start = 1'b0;
    frame_words = 24'hABCDEF;
    chk("busy_after_start", 64'(busy), 64'(1));
    for (int unsigned i = 0; i < ack_delay; i++) begin
      chk("wr_sw_high", 64'(wr_sw), 64'(1));
      if (i == ack_delay - 1) begin
        wr_sw_ack     = 1'b1;
        wr_start_addr = base;
      end
      step();
    end
    wr_sw_ack     = 1'b0;
    wr_start_addr = 32'hDEAD_0000;
    chk("wr_sw_low_after_ack", 64'(wr_sw), 64'(0));
  endtask

  task automatic wait_aw();
    for (int unsigned i = 0; i < 100; i++) begin
      if (aw_if.awvalid) break;
      step();
    end
    chk("awvalid_seen", 64'(aw_if.awvalid), 64'(1));
  endtask

  task automatic serve_burst(input int unsigned ready_delay, input int unsigned resp_delay,
                             input bit inject);
    burst_t e;
    wait_aw();
    chk("sb_nonempty", 64'(sb.size() != 0), 64'(1));
    if (sb.size() == 0) return;
    e = sb.pop_front();
    for (int unsigned i = 0; i < ready_delay; i++) begin
      if (i == 2) aw_if.burst_done = 1'b1;
      chk("bp_awvalid", 64'(aw_if.awvalid), 64'(1));
      chk("bp_awaddr",  64'(aw_if.awaddr),  64'(e.addr));
      chk("bp_awlen",   64'(aw_if.awlen),   64'(e.len));
      step();
      aw_if.burst_done = 1'b0;
    end
    chk("awaddr", 64'(aw_if.awaddr), 64'(e.addr));
    chk("awlen",  64'(aw_if.awlen),  64'(e.len));
    aw_if.awready = 1'b1;
    step();
    aw_if.awready = 1'b0;
    chk("no_dup_awvalid", 64'(aw_if.awvalid), 64'(0));
    for (int unsigned i = 0; i < resp_delay; i++) begin
      if (inject && i == 0) begin
        frame_start = 1'b1;
        frame_words = 24'd99;
      end
      step();
      frame_start = 1'b0;
    end
    aw_if.burst_done = 1'b1;
    step();
    aw_if.burst_done = 1'b0;
  endtask

  task automatic wait_done();
    bit seen;
    bit awv;
    seen = 1'b0;
    awv  = 1'b0;
    for (int unsigned i = 0; i < 50; i++) begin
      if (aw_if.awvalid) awv = 1'b1;
      if (frame_done) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    chk("frame_done_seen", 64'(seen), 64'(1));
    chk("no_extra_burst", 64'(awv), 64'(0));
    chk("sb_drained", 64'(sb.size()), 64'(0));
    step();
    chk("frame_done_single", 64'(frame_done), 64'(0));
    chk("idle_busy", 64'(busy), 64'(0));
  endtask

  initial begin
    n_vec            = 0;
    n_err            = 0;
    rst              = 1'b1;
    frame_start      = 1'b0;
    frame_words      = '0;
    fifo_rd_count    = 12'd64;
    wr_sw_ack        = 1'b0;
    wr_start_addr    = '0;
    aw_if.awready    = 1'b0;
    aw_if.burst_done = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    check_reset_vals("reset");
    step();

    // Full 40-word frame with a 5-cycle switch acknowledge.
    start_frame(24'd40, 32'h0000_1000, 5);
    serve_burst(0, 1, 1'b0);
    serve_burst(0, 3, 1'b0);
    serve_burst(0, 1, 1'b0);
    wait_done();

    // Address-channel backpressure, burst_done during ADDR must be ignored.
    start_frame(24'd20, 32'h0000_2000, 1);
    serve_burst(10, 2, 1'b0);
    serve_burst(0, 0, 1'b0);
    wait_done();

    // Data starvation: 15 words in FIFO cannot launch a 16-beat burst.
    fifo_rd_count = 12'd15;
    start_frame(24'd16, 32'h0000_3000, 2);
    for (int unsigned i = 0; i < 10; i++) begin
      chk("starve_no_awvalid", 64'(aw_if.awvalid), 64'(0));
      step();
    end
    fifo_rd_count = 12'd16;
    step();
    chk("starve_release", 64'(aw_if.awvalid), 64'(1));
    serve_burst(0, 2, 1'b0);
    wait_done();
    fifo_rd_count = 12'd64;

    // Overrun: frame_start during RESP, current frame unaffected.
    start_frame(24'd20, 32'h0000_4000, 1);
    serve_burst(0, 3, 1'b1);
    chk("overrun_set", 64'(overrun), 64'(1));
    serve_burst(0, 1, 1'b0);
    wait_done();
    chk("overrun_sticky", 64'(overrun), 64'(1));

    // Empty frame: switch handshake then frame_done with no bursts.
    start_frame(24'd0, 32'h0000_5000, 2);
    wait_done();

    // Address wrap at 2^32, and a one-beat tail burst.
    start_frame(24'd40, 32'hFFFF_FFE0, 1);
    serve_burst(0, 1, 1'b0);
    serve_burst(1, 1, 1'b0);
    serve_burst(0, 1, 1'b0);
    wait_done();
    start_frame(24'd17, 32'h0001_0000, 1);
    serve_burst(0, 1, 1'b0);
    serve_burst(0, 1, 1'b0);
    wait_done();

    // Reset while awvalid is high: nothing resumes afterwards.
    start_frame(24'd32, 32'h0000_6000, 1);
    wait_aw();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_vals("midrst");
    sb.delete();
    repeat (3) step();
    chk("no_resume_awvalid", 64'(aw_if.awvalid), 64'(0));
    chk("no_resume_busy", 64'(busy), 64'(0));
    start_frame(24'd8, 32'h0000_8000, 3);
    serve_burst(0, 1, 1'b0);
    wait_done();
    chk("clean_overrun", 64'(overrun), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/frame_wr_addr_gen.md
FRAME_WR_ADDR_GEN -- requirements
Module: frame_wr_addr_gen

Interface
REQ-001 SHALL have parameter BURST_LEN, default 16, meaning AXI beats per full write burst (1..256).
REQ-002 SHALL have parameter AXI_DATA_WIDTH, default 256, meaning AXI data bus width in bits; byte stride per beat = AXI_DATA_WIDTH/8.
REQ-003 SHALL have parameter ADDR_WIDTH, default 32, meaning the DDR byte address width.
REQ-004 ddr_clk  input  1  single clock for all logic.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 frame_start  input  1  single-cycle pulse marking the start of an input frame.
REQ-007 frame_words  input  24  AXI words per frame; sampled at frame_start.
REQ-008 fifo_rd_count  input  12  AXI words currently available in the upstream line FIFO.
REQ-009 wr_sw  output  1  bank-switch request to the frame-buffer bank switch.
REQ-010 wr_sw_ack  input  1  bank-switch acknowledge; wr_start_addr is valid in the cycle it is high.
REQ-011 wr_start_addr  input  ADDR_WIDTH  base byte address of the current write bank.
REQ-012 awaddr  output  ADDR_WIDTH  burst byte address.
REQ-013 awlen  output  8  beats minus one.
REQ-014 awvalid  output  1  address valid.
REQ-015 awready  input  1  address accepted.
REQ-016 burst_done  input  1  single-cycle pulse when the write response for the outstanding burst returns.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 frame_done  output  1  single-cycle pulse after the last burst of a frame completes.
REQ-019 overrun  output  1  sticky flag; frame_start arrived while busy.

Function
REQ-020 FSM states SHALL be IDLE, SWITCH, LOAD, WAIT_DATA, ADDR, RESP, DONE.
REQ-021 IDLE: on frame_start, latch frame_words into remaining and go to SWITCH.
REQ-022 SWITCH: hold wr_sw high; on wr_sw_ack high, drop wr_sw next cycle and go to LOAD.
REQ-023 LOAD: latch wr_start_addr into the address counter. If remaining == 0, go to DONE; otherwise go to WAIT_DATA.
REQ-024 WAIT_DATA: compute beats = min(BURST_LEN, remaining). Go to ADDR when fifo_rd_count >= beats.
REQ-025 ADDR: drive awvalid=1, awaddr = address counter, awlen = beats-1. Hold all three stable until awready; on awvalid&awready go to RESP.
REQ-026 RESP: on burst_done, add beats*(AXI_DATA_WIDTH/8) to the address counter and subtract beats from remaining. If the new remaining == 0, go to DONE; otherwise go to WAIT_DATA.
REQ-027 DONE: pulse frame_done for exactly one cycle, then go to IDLE.
REQ-028 Only one burst SHALL be outstanding at a time; burst_done outside RESP is ignored.
REQ-029 A frame_start in any non-IDLE state SHALL be ignored and SHALL set overrun, which clears only on rst.
REQ-030 wr_sw SHALL be low for at least one cycle between requests, so every request presents a fresh rising edge.
REQ-031 The address counter SHALL wrap modulo 2^ADDR_WIDTH; remaining arithmetic SHALL be 24-bit with no underflow.
REQ-032 The last burst of a frame SHALL be short when remaining < BURST_LEN (awlen = remaining-1).

Reset
REQ-033 While rst is high (sampled on ddr_clk), the block SHALL enter IDLE and drive wr_sw=0, awvalid=0, awaddr=0, awlen=0, busy=0, frame_done=0, overrun=0, and clear remaining.
REQ-034 rst asserted mid-burst (including while awvalid is high) SHALL drop awvalid in the next cycle; no burst is resumed after reset.

Verification
REQ-035 Full frame: frame_words=40, BURST_LEN=16, wr_start_addr=0x1000, fifo always 64 -> bursts at 0x1000/len15, 0x1200/len15, 0x1400/len7; then one frame_done pulse.
REQ-036 Handshake: wr_sw_ack delayed 5 cycles -> wr_sw held high 5 cycles and low 1 cycle after ack; awaddr base equals wr_start_addr sampled with ack.
REQ-037 Backpressure: awready low for 10 cycles -> awvalid, awaddr and awlen stable for all 10 cycles; no duplicate burst.
REQ-038 Data starvation: fifo_rd_count=15 with beats=16 -> no awvalid; raising it to 16 -> awvalid next cycle.
REQ-039 Overrun: second frame_start during RESP -> overrun=1, current frame completes unchanged; frame_words=0 -> switch handshake, then frame_done, no bursts.
REQ-040 Reset mid-ADDR: rst pulse while awvalid=1 -> all outputs at reset values next cycle; a subsequent frame_start starts a clean frame.
